// File: rtl/inout_sram_arbiter.sv
// Round-robin arbiter sharing the single-port InOut SRAM between N_REQ
// requesters. Supports a bounded burst lock, rejects out-of-range
// addresses before they reach the SRAM and steers read data back to the
// requester that issued the read.
module inout_sram_arbiter #(
    parameter int N_REQ     = 3,
    parameter int ADDR_W    = 18,
    parameter int DATA_W    = 16,
    parameter int MAX_WORDS = 196608,
    parameter int MAX_BURST = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [N_REQ-1:0]        req,
    input  logic [N_REQ-1:0]        req_we,
    input  logic [N_REQ-1:0]        req_lock,
    input  logic [N_REQ*ADDR_W-1:0] req_addr,
    input  logic [N_REQ*DATA_W-1:0] req_wdata,
    output logic [N_REQ-1:0]        gnt,
    output logic [N_REQ-1:0]        rvalid,
    output logic [DATA_W-1:0]       rdata,
    output logic [N_REQ-1:0]        err,
    output logic                    sram_cs,
    output logic                    sram_oe,
    output logic                    sram_web,
    output logic [ADDR_W-1:0]       sram_addr,
    output logic [DATA_W-1:0]       sram_wdata,
    input  logic [DATA_W-1:0]       sram_rdata
);

    localparam int                IDX_W    = $clog2(N_REQ);
    localparam int                CNT_W    = $clog2(MAX_BURST + 1);
    localparam logic [CNT_W-1:0]  CNT_MAX  = CNT_W'(MAX_BURST);
    localparam logic [ADDR_W:0]   LIMIT    = (ADDR_W + 1)'(MAX_WORDS);
    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(N_REQ - 1);
    localparam logic [N_REQ-1:0]  ONE_HOT0 = {{(N_REQ - 1){1'b0}}, 1'b1};

    typedef enum logic {
        S_IDLE,
        S_OWN
    } state_t;

    // Arbitration state
    state_t             state_q;
    logic [IDX_W-1:0]   ptr_q;
    logic [IDX_W-1:0]   owner_q;
    logic [CNT_W-1:0]   count_q;

    // Tag of the access issued last cycle, used to route the return
    logic               tag_valid_q;
    logic               tag_read_q;
    logic               tag_oob_q;
    logic [IDX_W-1:0]   tag_idx_q;

    // Last issued SRAM address / data, held while idle
    logic [ADDR_W-1:0]  addr_q;
    logic [DATA_W-1:0]  wdata_q;

    logic [ADDR_W-1:0]  addr_arr  [N_REQ];
    logic [DATA_W-1:0]  wdata_arr [N_REQ];
    logic [N_REQ-1:0]   oob;

    logic [N_REQ-1:0]   cand;
    logic               own_grant;
    logic               search_found;
    logic [IDX_W-1:0]   search_idx;
    logic [IDX_W-1:0]   win_idx;
    logic               grant_any;
    logic               issue_fire;
    logic               ret_read;

    // Unpack per-requester fields and flag out-of-range addresses
    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_req
        assign addr_arr[gi]  = req_addr[gi*ADDR_W +: ADDR_W];
        assign wdata_arr[gi] = req_wdata[gi*DATA_W +: DATA_W];
        assign oob[gi]       = ({1'b0, addr_arr[gi]} >= LIMIT);
    end

    function automatic logic [IDX_W-1:0] wrap_idx(input logic [IDX_W-1:0] base, input int off);
        int s;
        s = int'(base) + off;
        if (s >= N_REQ) begin
            s = s - N_REQ;
        end
        return IDX_W'(s);
    endfunction

    function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] w);
        return (w == LAST_IDX) ? '0 : w + 1'b1;
    endfunction

    // Owner keeps the grant while it requests, locks and has burst budget;
    // on release the owner sits out the cycle and the others compete.
    always_comb begin
        cand      = req;
        own_grant = 1'b0;
        if (state_q == S_OWN) begin
            own_grant = req[owner_q] & req_lock[owner_q] & (count_q < CNT_MAX);
            cand      = req & ~(ONE_HOT0 << owner_q);
        end
    end

    // Round-robin search from ptr upward with wrap; lowest offset wins
    always_comb begin
        search_found = 1'b0;
        search_idx   = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            if (cand[wrap_idx(ptr_q, k)]) begin
                search_found = 1'b1;
                search_idx   = wrap_idx(ptr_q, k);
            end
        end
    end

    assign win_idx    = own_grant ? owner_q : search_idx;
    assign grant_any  = ~rst & (own_grant | search_found);
    assign issue_fire = grant_any & ~oob[win_idx];

    assign gnt        = grant_any ? (ONE_HOT0 << win_idx) : '0;
    assign sram_cs    = issue_fire;
    assign sram_web   = ~(issue_fire & req_we[win_idx]);
    assign sram_addr  = rst ? '0 : (issue_fire ? addr_arr[win_idx]  : addr_q);
    assign sram_wdata = rst ? '0 : (issue_fire ? wdata_arr[win_idx] : wdata_q);

    // Return path: reset masks any in-flight tag immediately
    assign ret_read = ~rst & tag_valid_q & tag_read_q;
    assign rvalid   = ret_read ? (ONE_HOT0 << tag_idx_q) : '0;
    assign err      = (~rst & tag_valid_q & tag_oob_q) ? (ONE_HOT0 << tag_idx_q) : '0;
    assign sram_oe  = ret_read & ~tag_oob_q;
    assign rdata    = sram_oe ? sram_rdata : '0;

    // Arbitration FSM, return tag and held SRAM bus values
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            ptr_q       <= '0;
            owner_q     <= '0;
            count_q     <= '0;
            tag_valid_q <= 1'b0;
            tag_read_q  <= 1'b0;
            tag_oob_q   <= 1'b0;
            tag_idx_q   <= '0;
            addr_q      <= '0;
            wdata_q     <= '0;
        end else begin
            tag_valid_q <= grant_any;
            tag_read_q  <= ~req_we[win_idx];
            tag_oob_q   <= oob[win_idx];
            tag_idx_q   <= win_idx;
            if (issue_fire) begin
                addr_q  <= addr_arr[win_idx];
                wdata_q <= wdata_arr[win_idx];
            end
            if (own_grant) begin
                count_q <= count_q + 1'b1;
            end else begin
                state_q <= S_IDLE;
                count_q <= '0;
                if (search_found) begin
                    ptr_q <= next_idx(search_idx);
                    // A burst budget of one makes the lock meaningless
                    if (req_lock[search_idx] && (MAX_BURST > 1)) begin
                        state_q <= S_OWN;
                        owner_q <= search_idx;
                        count_q <= CNT_W'(1);
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_inout_sram_arbiter.sv
// Bench for inout_sram_arbiter: SRAM model, behavioural reference model
// checked every cycle, and directed vectors with literal expectations.
module tb_inout_sram_arbiter;

    localparam int N    = 3;
    localparam int AW   = 18;
    localparam int DW   = 16;
    localparam int MAXW = 196608;
    localparam int MB   = 4;

    logic            clk;
    logic            rst;
    logic [N-1:0]    req, req_we, req_lock;
    logic [N*AW-1:0] req_addr;
    logic [N*DW-1:0] req_wdata;
    logic [N-1:0]    gnt, rvalid, err;
    logic [DW-1:0]   rdata;
    logic            sram_cs, sram_oe, sram_web;
    logic [AW-1:0]   sram_addr;
    logic [DW-1:0]   sram_wdata;
    logic [DW-1:0]   sram_rdata;

    int vectors     = 0;
    int miscompares = 0;

    inout_sram_arbiter #(
        .N_REQ(N), .ADDR_W(AW), .DATA_W(DW), .MAX_WORDS(MAXW), .MAX_BURST(MB)
    ) dut (
        .clk(clk), .rst(rst), .req(req), .req_we(req_we), .req_lock(req_lock),
        .req_addr(req_addr), .req_wdata(req_wdata), .gnt(gnt), .rvalid(rvalid),
        .rdata(rdata), .err(err), .sram_cs(sram_cs), .sram_oe(sram_oe),
        .sram_web(sram_web), .sram_addr(sram_addr), .sram_wdata(sram_wdata),
        .sram_rdata(sram_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] init_val(input int i);
        if (i == 16)       return 16'hBEEF;
        if (i == MAXW - 1) return 16'h5A5A;
        return 16'(i * 7 + 3);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // SRAM model: capture the bus mid-cycle, act on the rising edge
    logic [15:0] mem [0:MAXW-1];
    initial begin
        logic          s_cs, s_web;
        logic [AW-1:0] s_addr;
        logic [DW-1:0] s_wd;
        sram_rdata = '0;
        for (int i = 0; i < MAXW; i++) mem[i] = init_val(i);
        forever begin
            @(negedge clk);
            s_cs = sram_cs; s_web = sram_web; s_addr = sram_addr; s_wd = sram_wdata;
            @(posedge clk);
            if (s_cs && int'(s_addr) < MAXW) begin
                if (!s_web) mem[s_addr] = s_wd;
                else        sram_rdata = mem[s_addr];
            end
        end
    end

    // Reference model: arbitration rules applied to the inputs each cycle
    logic [15:0] shadow [0:MAXW-1];
    int          ptr_m, owner_m, cnt_m;
    bit          pv, pread, poob;
    int          pidx;
    logic [15:0] pdata;
    initial begin
        logic [N-1:0] e_gnt, e_rv, e_err, elig;
        logic [15:0]  e_rdata;
        bit           e_cs, e_oe, e_web, found;
        int           win, a, c;
        for (int i = 0; i < MAXW; i++) shadow[i] = init_val(i);
        ptr_m = 0; owner_m = -1; cnt_m = 0; pv = 0; pread = 0; poob = 0; pidx = 0; pdata = '0;
        forever begin
            @(negedge clk);
            e_gnt = '0; e_rv = '0; e_err = '0; e_rdata = '0; e_cs = 0; e_oe = 0; e_web = 1;
            if (rst) begin
                ptr_m = 0; owner_m = -1; cnt_m = 0; pv = 0;
                chk("m_rst_addr", 32'(sram_addr), 0);
                chk("m_rst_wdata", 32'(sram_wdata), 0);
                chk("m_rst_rdata", 32'(rdata), 0);
            end else begin
                if (pv) begin
                    if (pread) e_rv[pidx] = 1'b1;
                    if (poob)  e_err[pidx] = 1'b1;
                    if (pread && !poob) begin e_oe = 1; e_rdata = pdata; end
                end
                win = -1;
                elig = req;
                if (owner_m >= 0) begin
                    if (req[owner_m] && req_lock[owner_m] && cnt_m < MB) begin
                        win = owner_m; cnt_m++;
                    end else begin
                        elig[owner_m] = 1'b0; owner_m = -1; cnt_m = 0;
                    end
                end
                if (win < 0) begin
                    found = 0;
                    for (int k = 0; k < N; k++) begin
                        c = (ptr_m + k) % N;
                        if (!found && elig[c]) begin found = 1; win = c; end
                    end
                    if (win >= 0) begin
                        ptr_m = (win + 1) % N;
                        if (req_lock[win] && MB > 1) begin owner_m = win; cnt_m = 1; end
                    end
                end
                pv = 0;
                if (win >= 0) begin
                    e_gnt[win] = 1'b1;
                    a = int'(req_addr[win*AW +: AW]);
                    pv = 1; pidx = win; pread = !req_we[win]; poob = (a >= MAXW); pdata = '0;
                    if (!poob) begin
                        e_cs = 1; e_web = !req_we[win];
                        chk("m_addr", 32'(sram_addr), 32'(a));
                        if (req_we[win]) begin
                            shadow[a] = req_wdata[win*DW +: DW];
                            chk("m_wdata", 32'(sram_wdata), 32'(req_wdata[win*DW +: DW]));
                        end else begin
                            pdata = shadow[a];
                        end
                    end
                end
                if (e_rv != 0) chk("m_rdata", 32'(rdata), 32'(e_rdata));
            end
            chk("m_gnt", 32'(gnt), 32'(e_gnt));
            chk("m_rvalid", 32'(rvalid), 32'(e_rv));
            chk("m_err", 32'(err), 32'(e_err));
            chk("m_cs", 32'(sram_cs), 32'(e_cs));
            chk("m_web", 32'(sram_web), 32'(e_web));
            chk("m_oe", 32'(sram_oe), 32'(e_oe));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_req();
        req = '0; req_we = '0; req_lock = '0;
    endtask

    task automatic set_req(input int i, input bit we, input bit lk, input int a, input int wd);
        logic [31:0] av, dv;
        av = 32'(a); dv = 32'(wd);
        req[i] = 1'b1; req_we[i] = we; req_lock[i] = lk;
        req_addr[i*AW +: AW] = av[AW-1:0];
        req_wdata[i*DW +: DW] = dv[DW-1:0];
    endtask

    // Directed vectors with hand-computed expectations, then a mixed loop
    initial begin
        logic [N-1:0] seq3 [6];
        int           a;
        seq3[0] = 3'b010; seq3[1] = 3'b010; seq3[2] = 3'b010;
        seq3[3] = 3'b010; seq3[4] = 3'b100; seq3[5] = 3'b001;
        rst = 1'b1; req_addr = '0; req_wdata = '0; clear_req();
        set_req(0, 0, 0, 16'h10, 0); set_req(1, 0, 0, 16'h20, 0); set_req(2, 0, 0, 16'h30, 0);

        // Reset with all requests high
        repeat (3) begin
            @(negedge clk);
            chk("rst_gnt", 32'(gnt), 0);
            chk("rst_web", 32'(sram_web), 1);
            tick();
        end
        rst = 1'b0;
        @(negedge clk); chk("rr_gnt0", 32'(gnt), 3'b001); tick();
        @(negedge clk); chk("rr_gnt1", 32'(gnt), 3'b010);
        chk("rr_rvalid0", 32'(rvalid), 3'b001);
        chk("rr_rdata0", 32'(rdata), 16'hBEEF);
        chk("rr_oe0", 32'(sram_oe), 1); tick();
        @(negedge clk); chk("rr_gnt2", 32'(gnt), 3'b100); tick();
        @(negedge clk); chk("rr_gnt0b", 32'(gnt), 3'b001); tick();

        // Lock by requester 1 with forced release after MB grants
        req_lock[1] = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk); chk($sformatf("lock_gnt%0d", i), 32'(gnt), 32'(seq3[i])); tick();
        end
        clear_req(); tick();

        // Single read latency
        set_req(0, 0, 0, 16'h10, 0);
        @(negedge clk); chk("rd_gnt", 32'(gnt), 3'b001); tick(); clear_req();
        @(negedge clk); chk("rd_rvalid", 32'(rvalid), 3'b001);
        chk("rd_rdata", 32'(rdata), 16'hBEEF); chk("rd_oe", 32'(sram_oe), 1); tick();

        // Out-of-range read, then last valid word
        set_req(2, 0, 0, MAXW, 0);
        @(negedge clk); chk("oob_gnt", 32'(gnt), 3'b100); chk("oob_cs", 32'(sram_cs), 0); tick(); clear_req();
        @(negedge clk); chk("oob_rvalid", 32'(rvalid), 3'b100); chk("oob_err", 32'(err), 3'b100);
        chk("oob_rdata", 32'(rdata), 0); chk("oob_oe", 32'(sram_oe), 0); tick();
        set_req(2, 0, 0, MAXW - 1, 0);
        @(negedge clk); chk("last_gnt", 32'(gnt), 3'b100); chk("last_cs", 32'(sram_cs), 1);
        chk("last_addr", 32'(sram_addr), MAXW - 1); tick(); clear_req();
        @(negedge clk); chk("last_err", 32'(err), 0); chk("last_rvalid", 32'(rvalid), 3'b100);
        chk("last_rdata", 32'(rdata), 16'h5A5A); tick();

        // Out-of-range write: error only
        set_req(2, 1, 0, 200000, 16'h7777);
        @(negedge clk); chk("oobw_cs", 32'(sram_cs), 0); chk("oobw_web", 32'(sram_web), 1); tick(); clear_req();
        @(negedge clk); chk("oobw_err", 32'(err), 3'b100); chk("oobw_rvalid", 32'(rvalid), 0); tick();

        // Write then read of the same word on the next cycle
        set_req(0, 1, 0, 32'h2FFFF, 16'h1234);
        @(negedge clk); chk("wr_gnt", 32'(gnt), 3'b001); chk("wr_web", 32'(sram_web), 0); tick(); clear_req();
        set_req(1, 0, 0, 32'h2FFFF, 0);
        @(negedge clk); chk("wr_rd_gnt", 32'(gnt), 3'b010); tick(); clear_req();
        @(negedge clk); chk("wr_rd_rvalid", 32'(rvalid), 3'b010); chk("wr_rd_rdata", 32'(rdata), 16'h1234); tick();

        // Reset while a read is in flight
        set_req(0, 0, 0, 16'h20, 0);
        @(negedge clk); chk("rr6_gnt", 32'(gnt), 3'b001); tick(); clear_req(); rst = 1'b1;
        @(negedge clk); chk("rr6_rvalid", 32'(rvalid), 0); chk("rr6_err", 32'(err), 0); tick();
        tick(); rst = 1'b0;
        set_req(0, 0, 0, 16'h10, 0); set_req(1, 0, 0, 16'h20, 0); set_req(2, 0, 0, 16'h30, 0);
        @(negedge clk); chk("rr6_ptr0", 32'(gnt), 3'b001); tick(); clear_req();

        // Mixed traffic checked by the reference model
        for (int n = 0; n < 400; n++) begin
            for (int i = 0; i < N; i++) begin
                case ($urandom_range(0, 7))
                    0:       a = MAXW + int'($urandom_range(0, 100));
                    1:       a = MAXW - 1;
                    default: a = int'($urandom_range(0, 31));
                endcase
                set_req(i, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), a, int'($urandom_range(0, 65535)));
                req[i] = ($urandom_range(0, 3) != 0);
            end
            tick();
        end
        clear_req();
        repeat (3) tick();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
